// File: rtl/slice_pkg.sv
// rtl/slice_pkg.sv - shared types for the slice event arbiter
package slice_pkg;
    localparam int ID_W = 8;

    typedef enum logic [1:0] {
        KIND_SLICE    = 2'd0,
        KIND_MISS     = 2'd1,
        KIND_OBSTACLE = 2'd2,
        KIND_RSVD     = 2'd3
    } hit_kind_e;

    typedef struct packed {
        logic [ID_W-1:0] id;
        hit_kind_e       kind;
    } slot_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant; pointer holds the lane to search from next
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);
    logic [IDX_W-1:0] ptr;

    always_comb begin
        int lane;
        lane        = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            lane = (int'(ptr) + k) % N;
            if (!grant_valid && req[lane]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(lane);
                grant[lane] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
endmodule

// File: rtl/slice_event_arbiter.sv
// rtl/slice_event_arbiter.sv - serialises lane hit reports into game pulses
// Optional recent-ID dedup ring enabled by SLICE_DEDUP_EN.
module slice_event_arbiter
    import slice_pkg::*;
#(
    parameter int NUM_LANES         = 4,
    parameter int RECENT_DEPTH      = 4,
    parameter int OBSTACLE_COOLDOWN = 64
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      game_active_in,
    input  logic [NUM_LANES-1:0]      hit_valid_in,
    output logic [NUM_LANES-1:0]      hit_ready_out,
    input  logic [NUM_LANES*ID_W-1:0] hit_id_in,
    input  logic [NUM_LANES*2-1:0]    hit_kind_in,
    output logic                      block_sliced,
    output logic                      block_missed,
    output logic                      player_hit_by_obstacle,
    output logic [ID_W-1:0]           block_ID,
    output logic [7:0]                dropped_count_out
);
    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CD_W  = $clog2(OBSTACLE_COOLDOWN + 1);

    slot_t                  slot [NUM_LANES];
    logic [NUM_LANES-1:0]   slot_valid;
    logic [NUM_LANES-1:0]   grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_valid;
    logic [CD_W-1:0]        cooldown;
    slot_t                  cur;
    logic                   ring_hit;
    logic                   emit_slice, emit_miss, emit_obst, drop;

    assign hit_ready_out = ~slot_valid & {NUM_LANES{game_active_in}};
    assign cur           = slot[grant_idx];

    rr_arbiter #(.N(NUM_LANES), .IDX_W(IDX_W)) u_rr (
        .clk         (clk_in),
        .rst_n       (rst_n_in),
        .req         (slot_valid & {NUM_LANES{game_active_in}}),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

`ifdef SLICE_DEDUP_EN
    localparam int RP_W = (RECENT_DEPTH > 1) ? $clog2(RECENT_DEPTH) : 1;
    logic [ID_W-1:0]         ring_id [RECENT_DEPTH];
    logic [RECENT_DEPTH-1:0] ring_valid;
    logic [RP_W-1:0]         wr_ptr;

    always_comb begin
        ring_hit = 1'b0;
        for (int k = 0; k < RECENT_DEPTH; k++) begin
            if (ring_valid[k] && ring_id[k] == cur.id) ring_hit = 1'b1;
        end
    end

    // Only forwarded slices enter the ring; the oldest entry is overwritten.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            ring_valid <= '0;
            wr_ptr     <= '0;
            for (int k = 0; k < RECENT_DEPTH; k++) ring_id[k] <= '0;
        end else if (emit_slice) begin
            ring_id[wr_ptr]    <= cur.id;
            ring_valid[wr_ptr] <= 1'b1;
            wr_ptr <= (wr_ptr == RP_W'(RECENT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        end
    end
`else
    assign ring_hit = 1'b0;
`endif

    always_comb begin
        emit_slice = 1'b0;
        emit_miss  = 1'b0;
        emit_obst  = 1'b0;
        drop       = 1'b0;
        if (grant_valid) begin
            case (cur.kind)
                KIND_SLICE:    if (ring_hit) drop = 1'b1; else emit_slice = 1'b1;
                KIND_MISS:     if (ring_hit) drop = 1'b1; else emit_miss = 1'b1;
                KIND_OBSTACLE: if (cooldown == '0) emit_obst = 1'b1; else drop = 1'b1;
                default:       drop = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            slot_valid             <= '0;
            block_sliced           <= 1'b0;
            block_missed           <= 1'b0;
            player_hit_by_obstacle <= 1'b0;
            block_ID               <= '0;
            dropped_count_out      <= '0;
            cooldown               <= '0;
            for (int i = 0; i < NUM_LANES; i++) slot[i] <= '0;
        end else begin
            block_sliced           <= emit_slice;
            block_missed           <= emit_miss;
            player_hit_by_obstacle <= emit_obst;
            if (emit_slice || emit_miss) block_ID <= cur.id;
            if (drop && dropped_count_out != 8'hFF) dropped_count_out <= dropped_count_out + 8'd1;
            if (emit_obst) cooldown <= CD_W'(OBSTACLE_COOLDOWN);
            else if (cooldown != '0) cooldown <= cooldown - 1'b1;
            // A granted slot is not ready this cycle, so clear and capture never collide.
            for (int i = 0; i < NUM_LANES; i++) begin
                if (!game_active_in || grant[i]) begin
                    slot_valid[i] <= 1'b0;
                end else if (hit_valid_in[i] && hit_ready_out[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot[i]       <= '{id: hit_id_in[i*ID_W +: ID_W],
                                       kind: hit_kind_e'(hit_kind_in[i*2 +: 2])};
                end
            end
        end
    end
endmodule
